// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq - sequential 14-bit binary to 4-digit packed BCD converter.
// Runs a fixed 14-iteration shift-and-add-3 (double-dabble) sequence, then
// presents the result with a one-cycle done pulse for the display driver's ld.
// Values above 9999 saturate to 9999 and raise ovf.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high
//   start  in   1   request conversion of bin; honoured only while idle
//   bin    in   14  unsigned value, sampled on the accepting edge
//   bcd    out  16  packed BCD {thousands, hundreds, tens, ones}, registered
//   done   out  1   one-cycle pulse when bcd/ovf update
//   busy   out  1   conversion in progress
//   ovf    out  1   last accepted bin exceeded 9999, held until next result
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state;
  logic [29:0] sr;           // {bcd digits[29:14], binary remainder[13:0]}
  logic [3:0]  cnt;
  logic        ovf_pending;
  logic [29:0] corr;
  logic [29:0] shifted;

  // A nibble >= 5 is at most 9 here, so 4-bit add never carries out.
  always_comb begin
    corr = sr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sr[14 + 4*i +: 4] >= 4'd5)
        corr[14 + 4*i +: 4] = sr[14 + 4*i +: 4] + 4'd3;
    end
    shifted = {corr[28:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr          <= {16'b0, bin};
            ovf_pending <= (bin > 14'd9999);
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= shifted;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13) begin
            bcd   <= ovf_pending ? 16'h9999 : shifted[29:14];
            ovf   <= ovf_pending;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq - directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        done;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive start for exactly one rising edge (edge k); returns #1 after it.
  task automatic pulse_start(input logic [13:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] eb, input logic eo);
    int lat;
    int busy_gaps;
    pulse_start(v);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    lat = 0;
    busy_gaps = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && !busy) busy_gaps++;
    end
    check({tag, "_lat"}, lat, 32'd14);
    check({tag, "_busygap"}, busy_gaps, 32'd0);
    check({tag, "_bcd"}, {16'b0, bcd}, {16'b0, eb});
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_donepulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, {16'b0, bcd}, {16'b0, eb});
  endtask

  initial begin
    int lat;
    int cnt;
    int unstable;
    logic [15:0] prev;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #12;
    check("rst_bcd",  {16'b0, bcd}, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf",  {31'b0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    convert("c1234", 14'd1234, 16'h1234, 1'b0);
    convert("c0", 14'd0, 16'h0000, 1'b0);
    convert("c9999", 14'd9999, 16'h9999, 1'b0);
    convert("c10000", 14'd10000, 16'h9999, 1'b1);
    convert("c16383", 14'd16383, 16'h9999, 1'b1);

    // Asynchronous reset between edges with nonzero outputs held.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_bcd", {16'b0, bcd}, 32'h0);
    check("arst_ovf", {31'b0, ovf}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Busy lockout: second start at edge k+5 is ignored.
    pulse_start(14'd42);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bin   = 14'd777;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("lock_busy", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lock_lat", lat, 32'd9);
    check("lock_bcd", {16'b0, bcd}, 32'h0042);
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("lock_nodone", cnt, 32'd0);

    // Reset mid-conversion aborts without done.
    pulse_start(14'd5678);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_bcd", {16'b0, bcd}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("mid_nodone", cnt, 32'd0);
    convert("c9", 14'd9, 16'h0009, 1'b0);

    // Back-to-back with start held high.
    prev = bcd;
    @(negedge clk);
    bin   = 14'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      lat = 0;
      unstable = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
        if (!done && bcd !== prev) unstable++;
      end while (!done && lat < 40);
      check($sformatf("b2b%0d_gap", n), lat, (n == 0) ? 32'd14 : 32'd15);
      check($sformatf("b2b%0d_bcd", n), {16'b0, bcd}, 32'h0100 + n);
      check($sformatf("b2b%0d_stable", n), unstable, 32'd0);
      prev = bcd;
      if (n < 2) bin = 14'(101 + n);
      else       start = 1'b0;
    end
    repeat (20) @(posedge clk);
    #1;
    check("b2b_end_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
